// File: rtl/bram_mem_ctrl.sv
// rtl/bram_mem_ctrl.sv - single-port byte-maskable block RAM with valid/ready requests
// Optional post-reset zeroing sweep; reads return one cycle after acceptance.
module bram_mem_ctrl #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 10,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_be,
  output logic                    rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    busy
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam int DEPTH    = 1 << ADDR_WIDTH;

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_RUN   = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   clr_cnt_q, clr_cnt_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  logic                    accept;
  logic                    mem_we;
  logic                    mem_re;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic [BE_WIDTH-1:0]     mem_be;

  assign accept    = req_valid && (state_q == S_RUN);
  assign req_ready = (state_q == S_RUN);
  assign busy      = (state_q == S_CLEAR);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;

  // The clear sweep and the request path share the single RAM port.
  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    mem_we      = 1'b0;
    mem_re      = 1'b0;
    mem_addr    = req_addr;
    mem_wdata   = req_wdata;
    mem_be      = req_be;
    case (state_q)
      S_CLEAR: begin
        mem_we    = 1'b1;
        mem_addr  = clr_cnt_q;
        mem_wdata = '0;
        mem_be    = '1;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == {ADDR_WIDTH{1'b1}}) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        mem_we = accept && req_we;
        mem_re = accept && !req_we;
      end
    endcase
    rsp_valid_d = mem_re;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_RUN;
      clr_cnt_q   <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  // Array carries no reset so it maps onto EBR; writes are suppressed while in reset.
  always_ff @(posedge clk) begin
    if (rst_n && mem_we) begin
      for (int i = 0; i < BE_WIDTH; i++) begin
        if (mem_be[i]) begin
          mem_q[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_rdata_q <= '0;
    end else if (mem_re) begin
      rsp_rdata_q <= mem_q[mem_addr];
    end
  end

endmodule

// File: tb/tb_bram_mem_ctrl.sv
// tb/tb_bram_mem_ctrl.sv - randomized bench with word-array reference model for bram_mem_ctrl
// dut_c clears on reset, dut_n does not; both share the request inputs.
module tb_bram_mem_ctrl;

  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int BW    = DW / 8;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n_c, rst_n_n;
  logic          req_valid, req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [BW-1:0] req_be;
  logic          ready_c, busy_c, valid_c;
  logic [DW-1:0] rdata_c;
  logic          ready_n, busy_n, valid_n;
  logic [DW-1:0] rdata_n;

  int checks = 0;
  int errors = 0;

  logic [31:0] ref_c [DEPTH];
  logic [31:0] ref_n [DEPTH];
  bit          known_n [DEPTH];
  bit          run_c = 0, run_n = 0;
  int          clr_c = 0;
  bit          exp_vc = 0, exp_vn = 0, exp_dn_known = 0;
  logic [31:0] exp_dc = '0, exp_dn = '0;

  always #5 clk = ~clk;

  bram_mem_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CLEAR_ON_RESET(1)) dut_c (
    .clk(clk), .rst_n(rst_n_c), .req_valid(req_valid), .req_ready(ready_c),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(valid_c), .rsp_rdata(rdata_c), .busy(busy_c)
  );

  bram_mem_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CLEAR_ON_RESET(0)) dut_n (
    .clk(clk), .rst_n(rst_n_n), .req_valid(req_valid), .req_ready(ready_n),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(valid_n), .rsp_rdata(rdata_n), .busy(busy_n)
  );

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  // Drive one cycle of stimulus and advance the reference model across the edge.
  task automatic drive(input bit v, input bit we, input int addr, input logic [31:0] d,
                       input logic [3:0] be);
    bit acc_c, acc_n;
    req_valid = v;
    req_we    = we;
    req_addr  = addr[AW-1:0];
    req_wdata = d;
    req_be    = be;
    acc_c = v && run_c && rst_n_c;
    acc_n = v && run_n && rst_n_n;
    @(posedge clk);
    exp_vc = 0;
    exp_vn = 0;
    if (!rst_n_c) begin
      run_c  = 0;
      clr_c  = 0;
      exp_dc = '0;
    end else if (!run_c) begin
      clr_c++;
      if (clr_c == DEPTH) begin
        run_c = 1;
        for (int i = 0; i < DEPTH; i++) ref_c[i] = '0;
      end
    end else if (acc_c) begin
      if (we) ref_c[addr] = merge(ref_c[addr], d, be);
      else begin
        exp_vc = 1;
        exp_dc = ref_c[addr];
      end
    end
    if (!rst_n_n) begin
      run_n        = 1;
      exp_dn       = '0;
      exp_dn_known = 1;
    end else if (acc_n) begin
      if (we) begin
        ref_n[addr]   = merge(ref_n[addr], d, be);
        known_n[addr] = known_n[addr] || (be == 4'hF);
      end else begin
        exp_vn       = 1;
        exp_dn       = ref_n[addr];
        exp_dn_known = known_n[addr];
      end
    end
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, '0, '0);
  endtask

  task automatic test_reset();
    rst_n_c = 0;
    rst_n_n = 0;
    idle();
    idle();
    checks++;
    if (busy_c !== 1'b1 || ready_c !== 1'b0) begin
      errors++;
      $display("FAIL reset_c busy=%b ready=%b required busy=1 ready=0", busy_c, ready_c);
    end
    checks++;
    if (valid_c !== 1'b0 || rdata_c !== 32'h0 || valid_n !== 1'b0 || rdata_n !== 32'h0) begin
      errors++;
      $display("FAIL reset_rsp vc=%b dc=%h vn=%b dn=%h required all zero", valid_c, rdata_c, valid_n, rdata_n);
    end
    checks++;
    if (busy_n !== 1'b0 || ready_n !== 1'b1) begin
      errors++;
      $display("FAIL reset_n busy=%b ready=%b required busy=0 ready=1", busy_n, ready_n);
    end
    rst_n_c = 1;
    rst_n_n = 1;
    for (int k = 1; k <= DEPTH; k++) begin
      if (k == 10) drive(1, 1, 2, 32'hFFFF_FFFF, 4'hF);
      else idle();
      checks++;
      if (k < DEPTH && (busy_c !== 1'b1 || ready_c !== 1'b0)) begin
        errors++;
        $display("FAIL clear_busy cycle=%0d busy=%b ready=%b required busy=1 ready=0", k, busy_c, ready_c);
      end else if (k == DEPTH && (busy_c !== 1'b0 || ready_c !== 1'b1)) begin
        errors++;
        $display("FAIL clear_done busy=%b ready=%b required busy=0 ready=1", busy_c, ready_c);
      end
    end
    for (int a = 0; a < DEPTH; a++) begin
      drive(1, 0, a, '0, '0);
      checks++;
      if (valid_c !== 1'b1 || rdata_c !== 32'h0) begin
        errors++;
        $display("FAIL clear_read addr=%0d valid=%b data=%h required valid=1 data=00000000", a, valid_c, rdata_c);
      end
    end
    idle();
    checks++;
    if (valid_c !== 1'b0) begin
      errors++;
      $display("FAIL idle_valid valid=%b required 0", valid_c);
    end
  endtask

  task automatic test_byte_enables();
    drive(1, 1, 3, 32'hDEAD_BEEF, 4'b1111);
    drive(1, 1, 3, 32'h1122_3344, 4'b0101);
    drive(1, 0, 3, '0, '0);
    checks++;
    if (valid_c !== 1'b1 || rdata_c !== 32'hDE22_BE44) begin
      errors++;
      $display("FAIL byte_en_c valid=%b data=%h required valid=1 data=de22be44", valid_c, rdata_c);
    end
    checks++;
    if (valid_n !== 1'b1 || rdata_n !== 32'hDE22_BE44) begin
      errors++;
      $display("FAIL byte_en_n valid=%b data=%h required valid=1 data=de22be44", valid_n, rdata_n);
    end
    drive(1, 1, 3, 32'h5555_5555, 4'b0000);
    drive(1, 0, 3, '0, '0);
    checks++;
    if (rdata_c !== 32'hDE22_BE44) begin
      errors++;
      $display("FAIL be_zero data=%h required de22be44", rdata_c);
    end
    idle();
  endtask

  task automatic test_back_to_back();
    drive(1, 1, 5, 32'hA5A5_A5A5, 4'hF);
    checks++;
    if (ready_c !== 1'b1 || valid_c !== 1'b0) begin
      errors++;
      $display("FAIL b2b_wr ready=%b valid=%b required ready=1 valid=0", ready_c, valid_c);
    end
    drive(1, 0, 5, '0, '0);
    checks++;
    if (ready_c !== 1'b1 || valid_c !== 1'b1 || rdata_c !== 32'hA5A5_A5A5) begin
      errors++;
      $display("FAIL b2b_rd5 ready=%b valid=%b data=%h required 1 1 a5a5a5a5", ready_c, valid_c, rdata_c);
    end
    drive(1, 0, 6, '0, '0);
    checks++;
    if (ready_c !== 1'b1 || valid_c !== 1'b1 || rdata_c !== 32'h0) begin
      errors++;
      $display("FAIL b2b_rd6 ready=%b valid=%b data=%h required 1 1 00000000", ready_c, valid_c, rdata_c);
    end
    idle();
    checks++;
    if (valid_c !== 1'b0 || rdata_c !== 32'h0) begin
      errors++;
      $display("FAIL b2b_tail valid=%b data=%h required valid=0 data=00000000", valid_c, rdata_c);
    end
  endtask

  task automatic test_write_no_rsp();
    for (int k = 0; k < 8; k++) begin
      drive(1, 1, $urandom_range(DEPTH-1), $urandom, 4'($urandom));
      checks++;
      if (valid_c !== 1'b0 || rdata_c !== exp_dc || valid_n !== 1'b0) begin
        errors++;
        $display("FAIL wr_no_rsp k=%0d vc=%b dc=%h vn=%b required vc=0 dc=%h vn=0", k, valid_c, rdata_c, valid_n, exp_dc);
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 300; k++) begin
      int sel;
      sel = $urandom_range(9);
      if (sel == 0) idle();
      else drive(1, sel > 5, $urandom_range(DEPTH-1), $urandom, 4'($urandom));
      checks++;
      if (valid_c !== exp_vc || rdata_c !== exp_dc) begin
        errors++;
        $display("FAIL rand_c k=%0d valid=%b data=%h required valid=%b data=%h", k, valid_c, rdata_c, exp_vc, exp_dc);
      end
      checks++;
      if (valid_n !== exp_vn || (exp_dn_known && rdata_n !== exp_dn)) begin
        errors++;
        $display("FAIL rand_n k=%0d valid=%b data=%h required valid=%b data=%h", k, valid_n, rdata_n, exp_vn, exp_dn);
      end
    end
  endtask

  task automatic test_reset_mid_clear();
    rst_n_c = 0;
    idle();
    rst_n_c = 1;
    for (int k = 1; k <= 7; k++) idle();
    rst_n_c = 0;
    idle();
    rst_n_c = 1;
    checks++;
    if (busy_c !== 1'b1 || ready_c !== 1'b0) begin
      errors++;
      $display("FAIL midclr_rst busy=%b ready=%b required busy=1 ready=0", busy_c, ready_c);
    end
    for (int k = 1; k <= DEPTH; k++) begin
      idle();
      checks++;
      if (k < DEPTH && (busy_c !== 1'b1 || ready_c !== 1'b0)) begin
        errors++;
        $display("FAIL midclr_busy cycle=%0d busy=%b ready=%b required busy=1 ready=0", k, busy_c, ready_c);
      end else if (k == DEPTH && (busy_c !== 1'b0 || ready_c !== 1'b1)) begin
        errors++;
        $display("FAIL midclr_done busy=%b ready=%b required busy=0 ready=1", busy_c, ready_c);
      end
    end
    for (int a = DEPTH - 1; a >= 0; a--) begin
      drive(1, 0, a, '0, '0);
      checks++;
      if (valid_c !== 1'b1 || rdata_c !== 32'h0) begin
        errors++;
        $display("FAIL midclr_read addr=%0d valid=%b data=%h required valid=1 data=00000000", a, valid_c, rdata_c);
      end
    end
    idle();
  endtask

  task automatic test_reset_after_read();
    int budget;
    drive(1, 1, 2, 32'h1234_5678, 4'hF);
    drive(1, 0, 2, '0, '0);
    checks++;
    if (valid_n !== 1'b1 || rdata_n !== 32'h1234_5678) begin
      errors++;
      $display("FAIL rar_pre valid=%b data=%h required valid=1 data=12345678", valid_n, rdata_n);
    end
    rst_n_c = 0;
    rst_n_n = 0;
    drive(1, 1, 2, 32'hBAD0_BAD0, 4'hF);
    checks++;
    if (valid_n !== 1'b0 || rdata_n !== 32'h0 || valid_c !== 1'b0 || rdata_c !== 32'h0) begin
      errors++;
      $display("FAIL rar_rst vn=%b dn=%h vc=%b dc=%h required all zero", valid_n, rdata_n, valid_c, rdata_c);
    end
    rst_n_c = 1;
    rst_n_n = 1;
    checks++;
    if (ready_n !== 1'b1 || busy_n !== 1'b0 || ready_c !== 1'b0) begin
      errors++;
      $display("FAIL rar_ready ready_n=%b busy_n=%b ready_c=%b required 1 0 0", ready_n, busy_n, ready_c);
    end
    drive(1, 0, 2, '0, '0);
    checks++;
    if (valid_n !== 1'b1 || rdata_n !== 32'h1234_5678) begin
      errors++;
      $display("FAIL rar_post valid=%b data=%h required valid=1 data=12345678", valid_n, rdata_n);
    end
    checks++;
    if (valid_c !== 1'b0) begin
      errors++;
      $display("FAIL rar_clear_ignore valid=%b required 0", valid_c);
    end
    budget = 0;
    while (ready_c !== 1'b1 && budget < 2 * DEPTH) begin
      idle();
      budget++;
    end
    checks++;
    if (ready_c !== 1'b1 || budget != DEPTH - 1) begin
      errors++;
      $display("FAIL rar_clear_len ready=%b extra_cycles=%0d required ready=1 extra_cycles=%0d", ready_c, budget, DEPTH - 1);
    end
    drive(1, 0, 2, '0, '0);
    checks++;
    if (valid_c !== 1'b1 || rdata_c !== 32'h0) begin
      errors++;
      $display("FAIL rar_c_zero valid=%b data=%h required valid=1 data=00000000", valid_c, rdata_c);
    end
    idle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n_c   = 0;
    rst_n_n   = 0;
    req_valid = 0;
    req_we    = 0;
    req_addr  = '0;
    req_wdata = '0;
    req_be    = '0;
    test_reset();
    test_byte_enables();
    test_back_to_back();
    test_write_no_rsp();
    test_random();
    test_reset_mid_clear();
    test_reset_after_read();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
